output_module: RTL
==================

OUTPUT_MODULE -- requirements
Module: output_module

Interface
REQ-001 Parameter SCAN_DIV, default 100000, SHALL set the clk cycles per digit slot (1 kHz digit rate at 100 MHz).
REQ-002 Parameter BLINK_FRAMES, default 64, SHALL set the full scan frames per blink phase toggle.
REQ-003 clk  in  1  system clock; the block SHALL have only this one clock.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 en  in  1  scan enable; the prescaler advances only when high.
REQ-006 value_in  in  16  four hex digits; digit 0 = value_in[3:0].
REQ-007 dp_in  in  4  per-digit decimal point, 1 = lit.
REQ-008 blank_in  in  4  per-digit blank, 1 = dark.
REQ-009 blink_in  in  4  per-digit blink select.
REQ-010 load  in  1  request to capture value_in, dp_in, blank_in and blink_in.
REQ-011 ready  out  1  high when a load will be accepted.
REQ-012 an  out  4  digit anodes, active-low, one-hot.
REQ-013 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-014 dp_out  out  1  decimal point, active-low.
REQ-015 frame_tick  out  1  one-cycle pulse at each frame wrap.

Function
REQ-016 The prescaler SHALL count 0..SCAN_DIV-1 while en=1, assert an internal tick at SCAN_DIV-1, then wrap to 0.
REQ-017 On each tick, the digit index (2 bits) SHALL increment, wrapping from 3 to 0.
REQ-018 The tick that wraps the index from 3 to 0 SHALL be the frame wrap, and frame_tick SHALL pulse high on the cycle after it.
REQ-019 an, seg and dp_out SHALL be registered and SHALL update together one cycle after the tick, with an = ~(1 << index).
REQ-020 seg SHALL carry the standard hex glyphs 0-F, active-low (0 -> 7'h40, 8 -> 7'h00, F -> 7'h0E).
REQ-021 For a blanked digit, seg SHALL be 7'h7F and dp_out SHALL be 1, while an continues to scan.
REQ-022 The handshake SHALL be: load && ready captures the inputs into a shadow register, and ready goes low on the next cycle.
REQ-023 At the next frame wrap, the shadow SHALL be copied to the active register, and ready SHALL return high on the following cycle.
REQ-024 A load while ready=0 SHALL be ignored.
REQ-025 A load accepted on the same cycle as a frame wrap SHALL commit at the following frame wrap, not the current one.
REQ-026 While en=0, the prescaler, index and outputs SHALL hold; loads SHALL still be accepted, but the commit SHALL wait for a frame wrap.

Reset
REQ-027 rst SHALL asynchronously clear the prescaler, the index and the blink state.
REQ-028 On reset, the active and shadow blank SHALL be 4'hF and all other active and shadow fields SHALL be 0.
REQ-029 Reset values SHALL be: an=4'hF, seg=7'h7F, dp_out=1, frame_tick=0, ready=1.
REQ-030 A reset asserted mid-handshake SHALL discard the pending shadow contents.

Configuration
REQ-031 With BLINK_EN defined, a frame counter SHALL toggle the blink phase every BLINK_FRAMES frame wraps, and digits with blink=1 SHALL be blanked while the phase is 1.
REQ-032 Without BLINK_EN, no frame counter SHALL exist, blink_in SHALL be captured but ignored, and the port list SHALL be unchanged.

Structure
REQ-033 The hex glyph table, the SEG_OFF/AN_OFF constants and the digit-index width SHALL live in a shared package.
REQ-034 The hex-to-segment decode SHALL be one combinational sub-module named seg_decoder, with output_module holding all sequential logic.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-035 Reset, then run 20 cycles with en=1: an, seg and dp_out SHALL stay 4'hF/7'h7F/1 while an scans E,D,B,7 every 4 cycles.
REQ-036 load value_in=16'h12AF with blank_in=0: after the next frame wrap, the scan SHALL show digit0 seg=7'h0E, digit1 7'h08, digit2 7'h24, digit3 7'h79, and ready SHALL drop for exactly the capture-to-commit interval.
REQ-037 A second load while ready=0 (value 16'hFFFF) SHALL be ignored, so the display keeps 16'h12AF.
REQ-038 A load on the frame-wrap cycle SHALL commit exactly one frame later, with frame_tick counted.
REQ-039 Holding en=0 for 10 cycles SHALL freeze an and seg, and frame_tick SHALL not pulse.
REQ-040 With BLINK_EN and blink_in=4'b0001, digit0 SHALL alternate between its glyph and 7'h7F every 2 frames, while digits 1-3 stay steady; asserting rst mid-load SHALL give ready=1, an=4'hF and an unchanged dark display.

Source files
------------

// File: rtl/output_module_pkg.sv
// Shared constants for the multiplexed 4-digit seven-segment scanner: glyph table,
// inactive drive levels, digit-index width and the display record layout.
package output_module_pkg;

  localparam int IDX_W = 2;
  localparam int NDIG  = 4;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a}; entry i sits at HEX_GLYPH[i]
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  blink;
  } disp_t;

  localparam disp_t DISP_RST = '{value: 16'h0, dp: 4'h0, blank: 4'hF, blink: 4'h0};

endpackage

// File: rtl/output_module_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module seg_decoder (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);
  import output_module_pkg::*;

  assign o_seg = HEX_GLYPH[i_hex];

endmodule

// File: rtl/output_module.sv
// Four-digit multiplexed seven-segment driver with a shadow/active load handshake
// that commits at frame boundaries. Optional per-digit blinking under `BLINK_EN.
module output_module #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic [3:0]  blink_in,
  input  logic        load,
  output logic        ready,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_out,
  output logic        frame_tick
);
  import output_module_pkg::*;

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PRE_W-1:0] r_pre;
  logic [IDX_W-1:0] r_idx;
  disp_t            r_act;
  disp_t            r_shd;
  logic             r_ready;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic             r_ft;

  logic             w_tick;
  logic             w_wrap;
  logic [3:0]       w_nib;
  logic [6:0]       w_glyph;
  logic             w_blank;

  assign w_tick = en && (r_pre == PRE_W'(SCAN_DIV - 1));
  assign w_wrap = w_tick && (&r_idx);
  assign w_nib  = r_act.value[{r_idx, 2'b00} +: 4];

  seg_decoder u_seg_decoder (
    .i_hex (w_nib),
    .o_seg (w_glyph)
  );

`ifdef BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] r_fcnt;
  logic            r_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_wrap) begin
      if (r_fcnt == FC_W'(BLINK_FRAMES - 1)) begin
        r_fcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fcnt  <= r_fcnt + FC_W'(1);
      end
    end
  end

  assign w_blank = r_act.blank[r_idx] | (r_act.blink[r_idx] & r_phase);
`else
  // Blink bits are still latched so the load path is identical in both builds
  logic w_unused_blink;
  assign w_unused_blink = (^r_act.blink) ^ (BLINK_FRAMES == 0);
  assign w_blank        = r_act.blank[r_idx];
`endif

  // Outputs register the slot being left at each tick; the wrap tick therefore
  // shows digit 3 from the old record while the shadow commits alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre   <= '0;
      r_idx   <= '0;
      r_an    <= AN_OFF;
      r_seg   <= SEG_OFF;
      r_dp    <= 1'b1;
      r_ft    <= 1'b0;
      r_ready <= 1'b1;
      r_act   <= DISP_RST;
      r_shd   <= DISP_RST;
    end else begin
      r_ft <= w_wrap;
      if (en) begin
        r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      end
      if (w_tick) begin
        r_idx <= r_idx + IDX_W'(1);
        r_an  <= ~(4'b0001 << r_idx);
        r_seg <= w_blank ? SEG_OFF : w_glyph;
        r_dp  <= w_blank | ~r_act.dp[r_idx];
      end
      if (load && r_ready) begin
        r_shd   <= '{value: value_in, dp: dp_in, blank: blank_in, blink: blink_in};
        r_ready <= 1'b0;
      end else if (w_wrap && !r_ready) begin
        r_act   <= r_shd;
        r_ready <= 1'b1;
      end
    end
  end

  assign ready      = r_ready;
  assign an         = r_an;
  assign seg        = r_seg;
  assign dp_out     = r_dp;
  assign frame_tick = r_ft;

endmodule
